// File: rtl/regfile_pkg.sv
// Shared defaults, address type and helpers for the integer register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned NREG_DEF = 32;

  typedef logic [$clog2(NREG_DEF)-1:0] reg_addr_t;

  function automatic logic is_x0(input reg_addr_t addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/regfile_2w2r_sb_if.sv
// Decode/writeback-facing signal bundle of the register file: reads, writes, allocs and debug.
interface regfile_2w2r_sb_if
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN = XLEN_DEF,
  parameter  int unsigned NREG = NREG_DEF,
  localparam int unsigned AW   = $clog2(NREG)
);

  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] readdata1;
  logic [XLEN-1:0] readdata2;
  logic            rs1_busy;
  logic            rs2_busy;

  logic            we0;
  logic [AW-1:0]   wa0;
  logic [XLEN-1:0] wd0;
  logic            we1;
  logic [AW-1:0]   wa1;
  logic [XLEN-1:0] wd1;

  logic            alloc_en;
  logic [AW-1:0]   alloc_rd;

  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_data;

  // Pipeline side (decode + writeback).
  modport master (
    output rs1, rs2, we0, wa0, wd0, we1, wa1, wd1, alloc_en, alloc_rd, dbg_addr,
    input  readdata1, readdata2, rs1_busy, rs2_busy, dbg_data
  );

  // Register file side.
  modport slave (
    input  rs1, rs2, we0, wa0, wd0, we1, wa1, wd1, alloc_en, alloc_rd, dbg_addr,
    output readdata1, readdata2, rs1_busy, rs2_busy, dbg_data
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on alloc, cleared by writeback, masked by same-cycle writes.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned NREG = NREG_DEF,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we0_i,
  input  logic [AW-1:0] wa0_i,
  input  logic          we1_i,
  input  logic [AW-1:0] wa1_i,
  input  logic          alloc_en_i,
  input  logic [AW-1:0] alloc_rd_i,
  input  logic [AW-1:0] rs1_i,
  input  logic [AW-1:0] rs2_i,
  output logic          rs1_busy_o,
  output logic          rs2_busy_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  function automatic logic wr_hit(input logic [AW-1:0] addr);
    return (we0_i && (wa0_i == addr)) || (we1_i && (wa1_i == addr));
  endfunction

  // Alloc beats writeback: a new producer issued in the same cycle keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < int'(NREG); r++) begin
      if (alloc_en_i && (alloc_rd_i == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (wr_hit(AW'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy_o = ~reset & busy_q[rs1_i] & ~wr_hit(rs1_i);
  assign rs2_busy_o = ~reset & busy_q[rs2_i] & ~wr_hit(rs2_i);

endmodule

// File: rtl/regfile_2w2r_sb.sv
// Two-write/two-read integer register file with write-to-read bypass, busy scoreboard and debug port.
module regfile_2w2r_sb
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN = XLEN_DEF,
  parameter  int unsigned NREG = NREG_DEF,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  regfile_2w2r_sb_if.slave  rf
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];

  // Port 1 is applied last so it wins on an address collision; x0 is never written.
  always_comb begin
    mem_d = mem_q;
    if (rf.we0 && (rf.wa0 != '0)) begin
      mem_d[rf.wa0] = rf.wd0;
    end
    if (rf.we1 && (rf.wa1 != '0)) begin
      mem_d[rf.wa1] = rf.wd1;
    end
    mem_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  function automatic logic [XLEN-1:0] bypass_rd(
    input logic [AW-1:0]   rs,
    input logic            we0,
    input logic [AW-1:0]   wa0,
    input logic [XLEN-1:0] wd0,
    input logic            we1,
    input logic [AW-1:0]   wa1,
    input logic [XLEN-1:0] wd1,
    input logic [XLEN-1:0] stored
  );
    if (rs == '0)                   return '0;
    else if (we1 && (wa1 == rs))    return wd1;
    else if (we0 && (wa0 == rs))    return wd0;
    else                            return stored;
  endfunction

  assign rf.readdata1 = reset ? '0 : bypass_rd(rf.rs1, rf.we0, rf.wa0, rf.wd0,
                                               rf.we1, rf.wa1, rf.wd1, mem_q[rf.rs1]);
  assign rf.readdata2 = reset ? '0 : bypass_rd(rf.rs2, rf.we0, rf.wa0, rf.wd0,
                                               rf.we1, rf.wa1, rf.wd1, mem_q[rf.rs2]);

  // Debug view is the raw array after the last edge, deliberately without bypass.
  assign rf.dbg_data = (reset || (rf.dbg_addr == '0)) ? '0 : mem_q[rf.dbg_addr];

  regfile_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .we0_i      (rf.we0),
    .wa0_i      (rf.wa0),
    .we1_i      (rf.we1),
    .wa1_i      (rf.wa1),
    .alloc_en_i (rf.alloc_en),
    .alloc_rd_i (rf.alloc_rd),
    .rs1_i      (rf.rs1),
    .rs2_i      (rf.rs2),
    .rs1_busy_o (rf.rs1_busy),
    .rs2_busy_o (rf.rs2_busy)
  );

endmodule

// File: doc/regfile_2w2r_sb.md
Name: regfile_2w2r_sb

Overview:
Parametrised integer register file for the pipelined RISC-V core. Provides two read ports with same-cycle write-to-read bypass and two write ports with fixed priority. Includes a per-register busy scoreboard for hazard detection, a hardwired-zero x0, and a debug read port in place of fixed register taps. Sits between decode (reads and allocates) and writeback (writes); all writes happen on the rising clock edge.

Parameters:
XLEN, 64, data width in bits
NREG, 32, number of architectural registers; power of two, at least 2
AW, $clog2(NREG), register address width; derived, not overridden

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
rs1  in  AW  read address, port 1
rs2  in  AW  read address, port 2
readdata1  out  XLEN  read data, port 1
readdata2  out  XLEN  read data, port 2
rs1_busy  out  1  register rs1 has an outstanding producer
rs2_busy  out  1  register rs2 has an outstanding producer
we0  in  1  write enable, port 0 (low priority)
wa0  in  AW  write address, port 0
wd0  in  XLEN  write data, port 0
we1  in  1  write enable, port 1 (high priority)
wa1  in  AW  write address, port 1
wd1  in  XLEN  write data, port 1
alloc_en  in  1  mark alloc_rd busy (instruction issued)
alloc_rd  in  AW  destination register being allocated
dbg_addr  in  AW  debug read address
dbg_data  out  XLEN  debug read data; raw array contents, no bypass

Behaviour:
- Reset is synchronous. On a rising edge with reset=1, all registers clear to 0 and all busy bits clear to 0. Writes and allocs presented in that cycle are ignored.
- While reset=1: readdata1/2 = 0, rs1_busy/rs2_busy = 0, dbg_data = 0. All outputs are combinational, so this takes effect the same cycle.
- Write, single port: wa != 0 and we=1 updates the register at the edge.
- Write, same address on both ports: port 1 wins.
- Write to x0 is always discarded; x0 always reads 0.
- Read is combinational, zero latency. For each read port, in priority order:
  - rs == 0 → 0
  - else we1 and wa1 == rs → wd1
  - else we0 and wa0 == rs → wd0
  - else array contents.
- Bypass means a value written this cycle is visible to readers this cycle. This replaces the negedge-write scheme.
- Scoreboard: busy[NREG-1:0]; busy[0] is constant 0.
  - Next-state for r != 0: set if alloc_en and alloc_rd == r; else clear if (we0 and wa0 == r) or (we1 and wa1 == r); else hold.
  - Simultaneous alloc and write to the same r: alloc wins, busy stays 1, and the data write still occurs.
  - alloc to x0 is ignored.
- rsN_busy = busy[rsN] AND NOT (a write to rsN this cycle). A same-cycle alloc is not reflected until the next cycle.
- Writing a register that is not busy is legal: data updates, busy stays 0.
- Reset mid-operation: asserting reset with pending busy bits clears them. No writeback is lost silently, because the pipeline is flushed by the same reset.
- dbg_data = array[dbg_addr] (0 for dbg_addr = 0). Reflects contents after the last edge, with no bypass.

Decomposition:
- Package regfile_pkg holds:
  - XLEN_DEF = 64, NREG_DEF = 32
  - typedef logic [$clog2(NREG_DEF)-1:0] reg_addr_t
  - function is_x0(reg_addr_t)
- Sub-module regfile_scoreboard holds the busy-bit array, its set/clear/priority logic, and the busy lookup with write-clear masking.
- The top level holds the data array, write priority, bypass muxes and the debug port.

Test Plan:
- Reset, then read all 32 regs via dbg_addr → all 0, rs1_busy = rs2_busy = 0. Hold reset=1 while driving we1/wa1=5/wd1=0xAA; after release, dbg 5 → 0.
- we0, wa0=3, wd0=0x1234 with rs1=3 in the same cycle → readdata1=0x1234 that cycle; next cycle we0=0, rs1=3 → 0x1234; dbg 3 → 0x1234.
- Same-address write: we0 and we1 both to reg 7, wd0=0x11, wd1=0x22, rs2=7 → readdata2=0x22 that cycle; dbg 7 → 0x22 after the edge.
- x0 protection: we1, wa1=0, wd1=0xFFFF; alloc_en, alloc_rd=0; rs1=0 → readdata1=0 and rs1_busy=0, both same cycle and next.
- Scoreboard: alloc reg 9 → next cycle rs1=9 gives busy=1. Write reg 9 (wd=0x5) with rs1=9 → busy=0 and readdata1=5 that cycle. Alloc and write reg 9 in the same cycle → busy=1 next cycle, dbg 9 = new data.
- Mid-run reset: regs 4 and 6 busy, assert reset one cycle → busy clears; reads of 4 and 6 → 0 after release.
